prl2srl_gen: RTL and testbench

Parametrised parallel-to-serial converter, the next generation of the 8-bit serialiser. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per enabled clock, MSB- or LSB-first. Supports back-to-back words with no dead cycle, an optional inter-word gap, a stall input, and first/last bit markers. It sits between a register-mapped or stream data source and a bit-serial line driver.

---
 rtl/prl2srl_gen.sv | 118 +++++++++++
 tb/tb_prl2srl_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prl2srl_gen.sv
// Parallel-to-serial converter: accepts WIDTH-bit words over valid/ready and
// shifts them out one bit per enabled clock, with optional inter-word idle gap.
module prl2srl_gen #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0,
  parameter int GAP       = 0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic             prl_valid,
  input  logic [WIDTH-1:0] prl,
  output logic             prl_ready,
  output logic             srl,
  output logic             valid,
  output logic             first,
  output logic             last,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam bit HAS_GAP = (GAP > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic [WIDTH-1:0] buff_q, buff_d;
  logic [WIDTH-1:0] buff_shift;
  logic             at_last;
  logic             accept;

  // Handshake: a word transfers on a rising edge where prl_valid && prl_ready.
  // prl_ready is combinational and never depends on prl_valid.
  assign at_last   = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
  assign prl_ready = en && ((state_q == ST_IDLE) || (at_last && !HAS_GAP));
  assign accept    = prl_valid && prl_ready;

  assign valid     = en && (state_q == ST_SHIFT);
  assign first     = valid && (cnt_q == '0);
  assign last      = valid && at_last;
  assign srl       = (LSB_FIRST != 0) ? buff_q[0] : buff_q[WIDTH-1];
  assign state_dbg = state_q;

  // Zeros enter at the end opposite the output bit.
  always_comb begin
    buff_shift = '0;
    if (LSB_FIRST != 0) buff_shift = {1'b0, buff_q[WIDTH-1:1]};
    else                buff_shift = {buff_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    buff_d  = buff_q;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            buff_d  = prl;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (HAS_GAP) begin
              buff_d  = buff_shift;
              gap_d   = '0;
              state_d = ST_GAP;
            end else if (accept) begin
              buff_d  = prl;
            end else begin
              buff_d  = buff_shift;
              state_d = ST_IDLE;
            end
          end else begin
            buff_d = buff_shift;
            cnt_d  = cnt_q + CW'(1);
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      buff_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      buff_q  <= buff_d;
    end
  end

endmodule

// File: tb/tb_prl2srl_gen.sv
// Directed bench for prl2srl_gen: four parameter sets share one clock; a
// scoreboard queue holds {srl, first, last} expected for every live bit.
module tb_prl2srl_gen;

  logic        clock;
  logic        rst;
  logic        en;
  logic        drv_valid;
  logic [31:0] drv_prl;
  int          sel;

  logic a_pv, b_pv, c_pv, d_pv;
  logic a_ready, a_srl, a_valid, a_first, a_last;
  logic b_ready, b_srl, b_valid, b_first, b_last;
  logic c_ready, c_srl, c_valid, c_first, c_last;
  logic d_ready, d_srl, d_valid, d_first, d_last;
  logic [1:0] a_dbg, b_dbg, c_dbg, d_dbg;

  logic m_ready, m_srl, m_valid, m_first, m_last;
  logic [1:0] m_dbg;

  logic [2:0] exp_q[$];
  int checks;
  int errors;
  int vcount;

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign a_pv = drv_valid && (sel == 0);
  assign b_pv = drv_valid && (sel == 1);
  assign c_pv = drv_valid && (sel == 2);
  assign d_pv = drv_valid && (sel == 3);

  prl2srl_gen #(.WIDTH(8), .LSB_FIRST(0), .GAP(0)) u_a (
    .clock(clock), .rst(rst), .en(en), .prl_valid(a_pv), .prl(drv_prl[7:0]),
    .prl_ready(a_ready), .srl(a_srl), .valid(a_valid), .first(a_first),
    .last(a_last), .state_dbg(a_dbg));

  prl2srl_gen #(.WIDTH(8), .LSB_FIRST(1), .GAP(0)) u_b (
    .clock(clock), .rst(rst), .en(en), .prl_valid(b_pv), .prl(drv_prl[7:0]),
    .prl_ready(b_ready), .srl(b_srl), .valid(b_valid), .first(b_first),
    .last(b_last), .state_dbg(b_dbg));

  prl2srl_gen #(.WIDTH(8), .LSB_FIRST(0), .GAP(3)) u_c (
    .clock(clock), .rst(rst), .en(en), .prl_valid(c_pv), .prl(drv_prl[7:0]),
    .prl_ready(c_ready), .srl(c_srl), .valid(c_valid), .first(c_first),
    .last(c_last), .state_dbg(c_dbg));

  prl2srl_gen #(.WIDTH(12), .LSB_FIRST(0), .GAP(0)) u_d (
    .clock(clock), .rst(rst), .en(en), .prl_valid(d_pv), .prl(drv_prl[11:0]),
    .prl_ready(d_ready), .srl(d_srl), .valid(d_valid), .first(d_first),
    .last(d_last), .state_dbg(d_dbg));

  always_comb begin
    m_ready = a_ready; m_srl = a_srl; m_valid = a_valid;
    m_first = a_first; m_last = a_last; m_dbg = a_dbg;
    case (sel)
      1: begin m_ready = b_ready; m_srl = b_srl; m_valid = b_valid;
               m_first = b_first; m_last = b_last; m_dbg = b_dbg; end
      2: begin m_ready = c_ready; m_srl = c_srl; m_valid = c_valid;
               m_first = c_first; m_last = c_last; m_dbg = c_dbg; end
      3: begin m_ready = d_ready; m_srl = d_srl; m_valid = d_valid;
               m_first = d_first; m_last = d_last; m_dbg = d_dbg; end
      default: ;
    endcase
  end

  // Driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [31:0] word);
    int w;
    int idx;
    w = (sel == 3) ? 12 : 8;
    for (int i = 0; i < w; i++) begin
      idx = (sel == 1) ? i : (w - 1 - i);
      exp_q.push_back({word[idx], (i == 0), (i == w - 1)});
    end
  endtask

  // Scoreboard: every live bit pops one expected entry.
  task automatic observe();
    logic [2:0] e;
    if (m_valid === 1'b1) begin
      vcount++;
      if (exp_q.size() == 0) begin
        check("unexpected_bit", m_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("bit", {m_srl, m_first, m_last}, e);
      end
    end else begin
      check("idle_marks", {m_first, m_last}, 0);
    end
  endtask

  task automatic send(input logic [31:0] word);
    int budget;
    budget = 50;
    drv_prl = word;
    drv_valid = 1'b1;
    while (m_ready !== 1'b1 && budget > 0) begin
      cycle();
      observe();
      budget--;
    end
    check("ready_wait", (budget > 0), 1);
    push_word(word);
    cycle();
    drv_valid = 1'b0;
    observe();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; vcount = 0;
    rst = 1'b1; en = 1'b1; sel = 0; drv_valid = 1'b0; drv_prl = '0;
    #3;
    check("rst_outs", {m_srl, m_valid, m_first, m_last}, 0);
    check("rst_ready_en1", m_ready, 1);
    en = 1'b0;
    #1;
    check("rst_ready_en0", m_ready, 0);
    en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    check("idle_state", m_dbg, 0);

    // MSB-first single word
    sel = 0; vcount = 0;
    send(32'hA5);
    check("shift_state", m_dbg, 1);
    for (int i = 0; i < 9; i++) begin cycle(); observe(); end
    check("msb_count", vcount, 8);
    check("sb_empty_msb", exp_q.size(), 0);

    // LSB-first single word
    sel = 1; vcount = 0;
    send(32'h1E);
    for (int i = 0; i < 9; i++) begin cycle(); observe(); end
    check("lsb_count", vcount, 8);
    check("sb_empty_lsb", exp_q.size(), 0);

    // Back-to-back words with no dead cycle
    sel = 0; vcount = 0;
    send(32'hFF);
    drv_prl = 32'h00;
    drv_valid = 1'b1;
    for (int i = 1; i < 8; i++) begin
      cycle();
      observe();
      if (i == 7) begin
        check("b2b_ready_last", m_ready, 1);
        en = 1'b0;
        #1;
        check("b2b_ready_stalled", m_ready, 0);
        en = 1'b1;
        #1;
      end else begin
        check("b2b_ready_mid", m_ready, 0);
      end
    end
    push_word(32'h00);
    cycle();
    drv_valid = 1'b0;
    observe();
    for (int i = 0; i < 7; i++) begin cycle(); observe(); end
    check("b2b_contig", vcount, 16);
    for (int i = 0; i < 2; i++) begin cycle(); observe(); end
    check("b2b_after", vcount, 16);
    check("sb_empty_b2b", exp_q.size(), 0);

    // Inter-word gap of 3
    sel = 2; vcount = 0;
    send(32'h3C);
    drv_prl = 32'hC3;
    drv_valid = 1'b1;
    for (int i = 1; i < 8; i++) begin
      cycle(); observe();
      check("gap_ready_shift", m_ready, 0);
    end
    for (int g = 0; g < 3; g++) begin
      cycle(); observe();
      check("gap_valid", m_valid, 0);
      check("gap_ready", m_ready, 0);
      check("gap_state", m_dbg, 2);
    end
    cycle(); observe();
    check("gap_ready_idle", m_ready, 1);
    push_word(32'hC3);
    cycle();
    drv_valid = 1'b0;
    observe();
    check("gap_second_first", m_first, 1);
    for (int i = 0; i < 11; i++) begin cycle(); observe(); end
    check("gap_count", vcount, 16);
    check("sb_empty_gap", exp_q.size(), 0);

    // Stall in mid-word
    sel = 0; vcount = 0;
    send(32'hA5);
    cycle(); observe();
    cycle();
    en = 1'b0;
    #1;
    observe();
    check("stall_valid", m_valid, 0);
    check("stall_srl", m_srl, 1);
    cycle(); observe();
    check("stall_valid2", m_valid, 0);
    check("stall_srl2", m_srl, 1);
    en = 1'b1;
    #1;
    observe();
    for (int i = 0; i < 7; i++) begin cycle(); observe(); end
    check("stall_count", vcount, 8);
    check("sb_empty_stall", exp_q.size(), 0);

    // Asynchronous reset mid-word, WIDTH=12
    sel = 3; vcount = 0;
    send(32'h800);
    for (int i = 0; i < 4; i++) begin cycle(); observe(); end
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_srl", m_srl, 0);
    check("arst_state", m_dbg, 0);
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    check("arst_ready", m_ready, 1);
    vcount = 0;
    for (int i = 0; i < 14; i++) begin cycle(); observe(); end
    check("arst_no_bits", vcount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
